// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state type and width helper for the parameterised register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: decode, x0 zeroing, write bypass and masking during a clear sweep.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = clog2(NREGS)
) (
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [NREGS*XLEN-1:0] regs_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  clr_req_i,
    input  logic                  busy_i,
    output logic [XLEN-1:0]       rd_data_o
);

    logic bypass;

    // Forward only writes that will actually commit on the coming edge.
    assign bypass = wr_en_i && (wr_addr_i == rd_addr_i) && (wr_addr_i != '0)
                    && !busy_i && !clr_req_i;

    always_comb begin
        rd_data_o = '0;
        if (!busy_i) begin
            if (bypass) begin
                rd_data_o = wr_data_i;
            end else if (rd_addr_i != '0) begin
                rd_data_o = regs_i[rd_addr_i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Parameterised register file with x0 hardwired to zero, N read ports and a sequential clear sweep.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned N_READ   = 2,
    parameter int unsigned DISP_IDX = NREGS - 1,
    localparam int unsigned AW      = clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_READ*AW-1:0]   rd_addr,
    output logic [N_READ*XLEN-1:0] rd_data,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [XLEN-1:0]        disp_data
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NREGS*XLEN-1:0] regs_flat;

    assign busy = (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = AW'(1);
                end
            end
            CLEAR: begin
                // Stop on the last index; clr_req is ignored for the whole sweep.
                if (clr_ptr_q == LastIdx) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
        end else if (wr_en && (wr_addr != '0) && !clr_req) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Storage has no reset; the post-reset sweep brings it to zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        if (i == 0) begin : g_zero
            assign regs_flat[i*XLEN +: XLEN] = '0;
        end else begin : g_reg
            assign regs_flat[i*XLEN +: XLEN] = regs_q[i];
        end
    end

    assign disp_data = busy ? '0 : regs_flat[DISP_IDX*XLEN +: XLEN];

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd (
            .rd_addr_i (rd_addr[k*AW +: AW]),
            .regs_i    (regs_flat),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .clr_req_i (clr_req),
            .busy_i    (busy),
            .rd_data_o (rd_data[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: default 32x32 file with two read ports plus a small 8x16 file with three ports.
module tb_param_register_file;

    logic        clk;
    logic        rst;

    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic        wr_en_a;
    logic [4:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        clr_req_a;
    logic        busy_a;
    logic [31:0] disp_a;

    logic [8:0]  rd_addr_b;
    logic [47:0] rd_data_b;
    logic        wr_en_b;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic        clr_req_b;
    logic        busy_b;
    logic [15:0] disp_b;

    int n_checks = 0;
    int n_pass   = 0;

    param_register_file u_a (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_a),
        .rd_data   (rd_data_a),
        .wr_en     (wr_en_a),
        .wr_addr   (wr_addr_a),
        .wr_data   (wr_data_a),
        .clr_req   (clr_req_a),
        .busy      (busy_a),
        .disp_data (disp_a)
    );

    param_register_file #(
        .XLEN   (16),
        .NREGS  (8),
        .N_READ (3)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_b),
        .rd_data   (rd_data_b),
        .wr_en     (wr_en_b),
        .wr_addr   (wr_addr_b),
        .wr_data   (wr_data_b),
        .clr_req   (clr_req_b),
        .busy      (busy_b),
        .disp_data (disp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        rst       = 1'b1;
        rd_addr_a = '0;
        wr_en_a   = 1'b0;
        wr_addr_a = '0;
        wr_data_a = '0;
        clr_req_a = 1'b0;
        rd_addr_b = '0;
        wr_en_b   = 1'b0;
        wr_addr_b = '0;
        wr_data_b = '0;
        clr_req_b = 1'b0;

        // Reset acts before any clock edge.
        #2;
        check_eq("rst_busy_async", 32'(busy_a), 32'd1);
        check_eq("rst_ptr_async", 32'(u_a.clr_ptr_q), 32'd1);
        step();
        step();
        rst = 1'b0;

        // Post-reset sweep with a write held on x2 the whole time.
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd2;
        wr_data_a = 32'h0000_0055;
        rd_addr_a = {5'd9, 5'd2};
        n = 0;
        while (busy_a && n < 100) begin
            #1;
            check_eq("sweep_rd0_zero", rd_data_a[31:0], 32'h0);
            check_eq("sweep_rd1_zero", rd_data_a[63:32], 32'h0);
            step();
            n++;
        end
        check_eq("rst_sweep_len", 32'(n), 32'd31);
        wr_en_a = 1'b0;
        #1;
        check_eq("write_dropped_in_sweep", rd_data_a[31:0], 32'h0);

        // Small instance: 3 ports, disp on x7.
        check_eq("b_idle", 32'(busy_b), 32'd0);
        wr_en_b   = 1'b1;
        wr_addr_b = 3'd3;
        wr_data_b = 16'h1234;
        step();
        wr_addr_b = 3'd7;
        wr_data_b = 16'hA5A5;
        rd_addr_b = {3'd0, 3'd3, 3'd7};
        #1;
        check_eq("b_disp_no_bypass", 32'(disp_b), 32'h0);
        check_eq("b_port0_bypass", 32'(rd_data_b[15:0]), 32'hA5A5);
        step();
        wr_en_b = 1'b0;
        #1;
        check_eq("b_disp_after", 32'(disp_b), 32'hA5A5);
        check_eq("b_port0_x7", 32'(rd_data_b[15:0]), 32'hA5A5);
        check_eq("b_port1_x3", 32'(rd_data_b[31:16]), 32'h1234);
        check_eq("b_port2_x0", 32'(rd_data_b[47:32]), 32'h0);

        // Same-cycle bypass, then the stored value.
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd5;
        wr_data_a = 32'hDEAD_BEEF;
        rd_addr_a = {5'd0, 5'd5};
        #1;
        check_eq("bypass_x5", rd_data_a[31:0], 32'hDEAD_BEEF);
        step();
        wr_en_a = 1'b0;
        #1;
        check_eq("stored_x5", rd_data_a[31:0], 32'hDEAD_BEEF);

        // Writes to x0 never bypass or stick.
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd0;
        wr_data_a = 32'h1234_5678;
        rd_addr_a = {5'd0, 5'd0};
        #1;
        check_eq("x0_nobypass_p0", rd_data_a[31:0], 32'h0);
        check_eq("x0_nobypass_p1", rd_data_a[63:32], 32'h0);
        step();
        wr_en_a = 1'b0;
        #1;
        check_eq("x0_stored_p0", rd_data_a[31:0], 32'h0);
        check_eq("x0_stored_p1", rd_data_a[63:32], 32'h0);

        rd_addr_a = {5'd5, 5'd5};
        #1;
        check_eq("dup_addr_p0", rd_data_a[31:0], 32'hDEAD_BEEF);
        check_eq("dup_addr_p1", rd_data_a[63:32], 32'hDEAD_BEEF);

        // disp has no bypass, shows x31 one cycle after the write.
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd31;
        wr_data_a = 32'hCAFE_F00D;
        #1;
        check_eq("disp_no_bypass", disp_a, 32'h0);
        step();
        wr_en_a = 1'b0;
        #1;
        check_eq("disp_after_write", disp_a, 32'hCAFE_F00D);

        // Fill x1..x31 with their index.
        for (int i = 1; i < 32; i++) begin
            wr_en_a   = 1'b1;
            wr_addr_a = 5'(i);
            wr_data_a = 32'(i);
            step();
        end
        wr_en_a   = 1'b0;
        rd_addr_a = {5'd31, 5'd7};
        #1;
        check_eq("fill_x7", rd_data_a[31:0], 32'd7);
        check_eq("fill_x31", rd_data_a[63:32], 32'd31);
        check_eq("fill_disp", disp_a, 32'd31);

        // clr_req suppresses a same-cycle write and its bypass.
        clr_req_a = 1'b1;
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd4;
        wr_data_a = 32'h0000_FFFF;
        rd_addr_a = {5'd0, 5'd4};
        #1;
        check_eq("clr_blocks_bypass", rd_data_a[31:0], 32'd4);
        step();
        clr_req_a = 1'b0;
        wr_en_a   = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            clr_req_a = (n == 10);
            step();
            n++;
        end
        clr_req_a = 1'b0;
        check_eq("clr_sweep_len", 32'(n), 32'd31);
        for (int i = 1; i < 32; i++) begin
            rd_addr_a = {5'd0, 5'(i)};
            #1;
            check_eq("cleared_reg", rd_data_a[31:0], 32'h0);
        end

        // Reset in the middle of a sweep restarts it.
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd9;
        wr_data_a = 32'h0000_0099;
        step();
        wr_en_a   = 1'b0;
        clr_req_a = 1'b1;
        step();
        clr_req_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check_eq("mid_sweep_ptr", 32'(u_a.clr_ptr_q), 32'd16);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy_a), 32'd1);
        check_eq("mid_rst_ptr", 32'(u_a.clr_ptr_q), 32'd1);
        step();
        rst = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check_eq("mid_rst_sweep_len", 32'(n), 32'd31);
        rd_addr_a = {5'd0, 5'd9};
        #1;
        check_eq("x9_after_rst", rd_data_a[31:0], 32'h0);
        check_eq("disp_after_rst", disp_a, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4.
REQ-003 SHALL have parameter N_READ, default 2: number of independent read ports, 1..4.
REQ-004 SHALL have parameter DISP_IDX, default NREGS-1: index of the register mirrored on disp_data.
REQ-005 SHALL derive localparam AW = clog2(NREGS).
REQ-006 SHALL use one clock and an asynchronous, active-high reset, as listed in REQ-007 and REQ-008.
REQ-007 SHALL have port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have port: rd_addr  in  N_READ*AW  packed read addresses; port k occupies slice [k*AW +: AW].
REQ-010 SHALL have port: rd_data  out  N_READ*XLEN  packed read data; port k occupies slice [k*XLEN +: XLEN].
REQ-011 SHALL have port: wr_en  in  1  write request.
REQ-012 SHALL have port: wr_addr  in  AW  write register index.
REQ-013 SHALL have port: wr_data  in  XLEN  write data.
REQ-014 SHALL have port: clr_req  in  1  single-cycle request to zero the whole file.
REQ-015 SHALL have port: busy  out  1  high while a clear sweep is in progress.
REQ-016 SHALL have port: disp_data  out  XLEN  current contents of register DISP_IDX.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-018 SHALL use a sweep pointer clr_ptr of AW bits.
REQ-019 In IDLE with clr_req=1, SHALL go to CLEAR and set clr_ptr=1 on the next edge.
REQ-020 In CLEAR, SHALL write zero to register clr_ptr and increment clr_ptr on each edge.
REQ-021 In CLEAR, the edge that writes index NREGS-1 SHALL return the FSM to IDLE; no wrap-around past NREGS-1.
REQ-022 busy SHALL equal (state==CLEAR), so busy stays high for exactly NREGS-1 cycles per sweep.
REQ-023 clr_req received while in CLEAR SHALL be ignored; it neither restarts nor extends the sweep.
REQ-024 In IDLE with wr_en=1, wr_addr!=0 and clr_req=0, SHALL store wr_data at wr_addr on the edge.
REQ-025 A write with wr_en=1 SHALL be dropped if clr_req=1 in the same cycle or busy=1.
REQ-026 Register 0 SHALL always read as zero; writes to index 0 SHALL have no effect.
REQ-027 Reads SHALL be combinational with zero cycles of latency.
REQ-028 Each read port SHALL forward wr_data (bypass) when wr_en=1, wr_addr==rd_addr[k], wr_addr!=0, busy=0 and clr_req=0.
REQ-029 While busy=1, every rd_data slice and disp_data SHALL read zero.
REQ-030 disp_data SHALL show the stored value of DISP_IDX without bypass, updating the cycle after the write.
REQ-031 Identical addresses on several read ports SHALL return identical data.

Reset
REQ-032 Asserting rst SHALL immediately force state=CLEAR, clr_ptr=1 and busy=1.
REQ-033 Storage SHALL reach all-zero through the post-reset sweep, not through an asynchronous array clear.
REQ-034 rst asserted mid-sweep SHALL restart the sweep from index 1.
REQ-035 After rst deasserts, writes SHALL be accepted starting at cycle NREGS-1.

Structure
REQ-036 Package regfile_pkg SHALL hold the XLEN and NREGS defaults, the state enum {IDLE, CLEAR} and a clog2 function.
REQ-037 Sub-module regfile_read_port (address decode, x0 zeroing, bypass, busy masking) SHALL be instantiated N_READ times by generate.
REQ-038 The storage array and the FSM SHALL remain in the top module.

Verification
REQ-039 Apply rst, release it and hold wr_en=1 -> busy stays high 31 cycles, then drops; every read returns 0; writes are dropped until busy=0.
REQ-040 Write 0xDEADBEEF to x5 while port0 reads x5 in the same cycle -> rd_data[0] = 0xDEADBEEF combinationally; the next cycle it still reads 0xDEADBEEF from storage.
REQ-041 Write 0x12345678 to x0 -> every port reading x0 returns 0x00000000, with no bypass.
REQ-042 Fill x1..x31 with their index values, pulse clr_req, pulse it again at sweep cycle 10 -> busy lasts exactly 31 cycles and all registers read 0 afterwards.
REQ-043 Assert rst at sweep cycle 15 -> clr_ptr returns to 1 and busy lasts a further 31 cycles after release.
REQ-044 Instantiate with N_READ=3, XLEN=16, NREGS=8 and write x7=0xA5A5 -> disp_data = 0xA5A5 one cycle after the write edge, and all three ports read correctly.
